// File: rtl/sim_pkg.sv
// Shared types for the particle-simulation scheduler: the phase and
// handshake sub-state encodings, plus the default launch timeout.
// No ports. Imported by sim_scheduler and pass_launcher.
`timescale 1ns/1ps
package sim_pkg;

  // The encoding is visible on phase_out, so these values are fixed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    STEP  = 2'd2,
    DRAW  = 2'd3
  } phase_t;

  // Handshake with the pass that owns the current phase.
  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } launch_t;

  // Cycles to wait for busy before a launched pass counts as finished.
  // A pass that has zero particles to process never raises busy.
  localparam int unsigned DEFAULT_LAUNCH_TIMEOUT = 4;

endpackage

// File: rtl/sim_scheduler_pass_launcher.sv
// pass_launcher: start/busy handshake shared by every pass of the scheduler.
// Ports: go_in requests a launch, busy_in is the selected pass's busy,
//        start_out is the one-cycle launch pulse, done_out marks completion.
`timescale 1ns/1ps
module pass_launcher
  import sim_pkg::*;
#(
  parameter int unsigned LAUNCH_TIMEOUT = DEFAULT_LAUNCH_TIMEOUT
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic go_in,
  input  logic busy_in,
  output logic start_out,
  output logic done_out
);

  // The counter only has to reach LAUNCH_TIMEOUT-1; keep at least one bit.
  localparam int CW = (LAUNCH_TIMEOUT > 1) ? $clog2(LAUNCH_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(LAUNCH_TIMEOUT - 1);

  launch_t         state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_out = 1'b0;
    done_out  = 1'b0;
    case (state_q)
      // ISSUE doubles as the resting state: the pulse is only emitted
      // while the parent is in a non-IDLE phase.
      ISSUE: begin
        if (go_in) begin
          start_out = 1'b1;
          state_d   = WAIT_HI;
          cnt_d     = '0;
        end
      end
      WAIT_HI: begin
        if (busy_in) begin
          state_d = WAIT_LO;
        end else if (cnt_q == TMO_LAST) begin
          // Busy never came: treat as an empty pass.
          done_out = 1'b1;
          state_d  = ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!busy_in) begin
          done_out = 1'b1;
          state_d  = ISSUE;
        end
      end
      default: state_d = ISSUE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ISSUE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/sim_scheduler.sv
// sim_scheduler: sequences the reset, step and draw passes and grants the
// single particle-RAM port to whichever pass owns the current phase.
// Ports: restart_in/frame_tick_in requests; per-pass start/busy/addr/data;
//        mem_* RAM port; phase_out, frame_count_out, overrun_out status.
`timescale 1ns/1ps
module sim_scheduler
  import sim_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned RAM_WIDTH      = 64,
  parameter int unsigned LAUNCH_TIMEOUT = DEFAULT_LAUNCH_TIMEOUT
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  restart_in,
  input  logic                  frame_tick_in,
  output logic                  rst_start_out,
  input  logic                  rst_busy_in,
  input  logic [ADDR_WIDTH-1:0] rst_addr_in,
  input  logic [RAM_WIDTH-1:0]  rst_data_in,
  output logic                  step_start_out,
  input  logic                  step_busy_in,
  input  logic [ADDR_WIDTH-1:0] step_addr_in,
  input  logic [RAM_WIDTH-1:0]  step_data_in,
  input  logic                  step_we_in,
  output logic                  draw_start_out,
  input  logic                  draw_busy_in,
  input  logic [ADDR_WIDTH-1:0] draw_addr_in,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [RAM_WIDTH-1:0]  mem_data_out,
  output logic                  mem_we_out,
  output logic [1:0]            phase_out,
  output logic [15:0]           frame_count_out,
  output logic                  overrun_out
);

  phase_t      phase_q, phase_d;
  logic        init_q, init_d;
  logic        pend_q, pend_d;
  logic        ovr_q, ovr_d;
  logic [15:0] frame_q, frame_d;

  logic        pass_go;
  logic        pass_busy;
  logic        pass_start;
  logic        pass_done;

  // One launcher serves all phases; only the owning pass's busy is seen.
  assign pass_go = (phase_q != IDLE);

  always_comb begin
    pass_busy = 1'b0;
    case (phase_q)
      RESET:   pass_busy = rst_busy_in;
      STEP:    pass_busy = step_busy_in;
      DRAW:    pass_busy = draw_busy_in;
      default: pass_busy = 1'b0;
    endcase
  end

  pass_launcher #(
    .LAUNCH_TIMEOUT(LAUNCH_TIMEOUT)
  ) u_launcher (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .go_in    (pass_go),
    .busy_in  (pass_busy),
    .start_out(pass_start),
    .done_out (pass_done)
  );

  assign rst_start_out  = pass_start && (phase_q == RESET);
  assign step_start_out = pass_start && (phase_q == STEP);
  assign draw_start_out = pass_start && (phase_q == DRAW);

  always_comb begin
    phase_d = phase_q;
    init_d  = init_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    frame_d = frame_q;
    case (phase_q)
      IDLE: begin
        // An uninitialised scheduler behaves as if a restart were pending.
        if (!init_q || restart_in || pend_q) begin
          phase_d = RESET;
          pend_d  = 1'b0;
          // A tick arriving behind an older pending restart is lost;
          // a tick coincident with a fresh restart is not an overrun.
          if (frame_tick_in && pend_q && !restart_in) begin
            ovr_d = 1'b1;
          end
        end else if (frame_tick_in) begin
          phase_d = STEP;
        end
      end
      RESET: begin
        // restart_in is deliberately ignored here.
        if (frame_tick_in) begin
          ovr_d = 1'b1;
        end
        // Completion clears overrun even against a same-cycle tick.
        if (pass_done) begin
          phase_d = IDLE;
          init_d  = 1'b1;
          frame_d = '0;
          ovr_d   = 1'b0;
        end
      end
      STEP: begin
        if (frame_tick_in) begin
          ovr_d = 1'b1;
        end
        if (restart_in) begin
          pend_d = 1'b1;
        end
        if (pass_done) begin
          phase_d = DRAW;
        end
      end
      DRAW: begin
        if (frame_tick_in) begin
          ovr_d = 1'b1;
        end
        if (restart_in) begin
          pend_d = 1'b1;
        end
        if (pass_done) begin
          phase_d = IDLE;
          frame_d = frame_q + 16'd1;
        end
      end
      default: phase_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      phase_q <= IDLE;
      init_q  <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      phase_q <= phase_d;
      init_q  <= init_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      frame_q <= frame_d;
    end
  end

  // RAM port follows the registered phase, so an asynchronous reset
  // drops the write enable immediately.
  always_comb begin
    mem_addr_out = '0;
    mem_data_out = '0;
    mem_we_out   = 1'b0;
    case (phase_q)
      RESET: begin
        mem_addr_out = rst_addr_in;
        mem_data_out = rst_data_in;
        mem_we_out   = rst_busy_in;
      end
      STEP: begin
        mem_addr_out = step_addr_in;
        mem_data_out = step_data_in;
        mem_we_out   = step_we_in;
      end
      DRAW: begin
        mem_addr_out = draw_addr_in;
      end
      default: begin
        mem_addr_out = '0;
      end
    endcase
  end

  assign phase_out       = phase_q;
  assign frame_count_out = frame_q;
  assign overrun_out     = ovr_q;

endmodule

// File: tb/tb_sim_scheduler.sv
`timescale 1ns/1ps
module tb_sim_scheduler;

  localparam int AW = 11;
  localparam int RW = 64;
  localparam logic [AW-1:0] RST_ADDR  = 11'h123;
  localparam logic [AW-1:0] STEP_ADDR = 11'h456;
  localparam logic [AW-1:0] DRAW_ADDR = 11'h789;
  localparam logic [RW-1:0] RST_DATA  = 64'hA5A5_0000_1111_2222;
  localparam logic [RW-1:0] STEP_DATA = 64'h0123_4567_89AB_CDEF;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          restart_in = 1'b0;
  logic          frame_tick_in = 1'b0;
  logic          rst_start_out, step_start_out, draw_start_out;
  logic          rst_busy_in, step_busy_in, draw_busy_in;
  logic [AW-1:0] rst_addr_in = RST_ADDR;
  logic [AW-1:0] step_addr_in = STEP_ADDR;
  logic [AW-1:0] draw_addr_in = DRAW_ADDR;
  logic [RW-1:0] rst_data_in = RST_DATA;
  logic [RW-1:0] step_data_in = STEP_DATA;
  logic          step_we_in = 1'b1;
  logic [AW-1:0] mem_addr_out;
  logic [RW-1:0] mem_data_out;
  logic          mem_we_out;
  logic [1:0]    phase_out;
  logic [15:0]   frame_count_out;
  logic          overrun_out;

  int tests = 0;
  int fails = 0;

  sim_scheduler #(.ADDR_WIDTH(AW), .RAM_WIDTH(RW), .LAUNCH_TIMEOUT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .restart_in(restart_in), .frame_tick_in(frame_tick_in),
    .rst_start_out(rst_start_out), .rst_busy_in(rst_busy_in), .rst_addr_in(rst_addr_in),
    .rst_data_in(rst_data_in), .step_start_out(step_start_out), .step_busy_in(step_busy_in),
    .step_addr_in(step_addr_in), .step_data_in(step_data_in), .step_we_in(step_we_in),
    .draw_start_out(draw_start_out), .draw_busy_in(draw_busy_in), .draw_addr_in(draw_addr_in),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out), .mem_we_out(mem_we_out),
    .phase_out(phase_out), .frame_count_out(frame_count_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  // Pass models: busy rises the cycle after start and stays high for *_len cycles.
  int rst_len = 8, step_len = 5, draw_len = 3;
  int rst_left = 0, step_left = 0, draw_left = 0;
  always @(posedge clk_in) begin
    if (rst_start_out) rst_left <= rst_len; else if (rst_left > 0) rst_left <= rst_left - 1;
    if (step_start_out) step_left <= step_len; else if (step_left > 0) step_left <= step_left - 1;
    if (draw_start_out) draw_left <= draw_len; else if (draw_left > 0) draw_left <= draw_left - 1;
  end
  assign rst_busy_in  = (rst_left > 0);
  assign step_busy_in = (step_left > 0);
  assign draw_busy_in = (draw_left > 0);

  // Running event counts, sampled mid-cycle.
  int n_we = 0, n_draw_we = 0, n_rst_go = 0, n_step_go = 0, n_draw_go = 0;
  always @(negedge clk_in) begin
    if (mem_we_out) n_we <= n_we + 1;
    if (mem_we_out && phase_out == 2'd3) n_draw_we <= n_draw_we + 1;
    if (rst_start_out) n_rst_go <= n_rst_go + 1;
    if (step_start_out) n_step_go <= n_step_go + 1;
    if (draw_start_out) n_draw_go <= n_draw_go + 1;
  end

  // Advance to the middle of the next cycle (inputs are also driven here).
  task automatic mid();
    @(negedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    int we0, go0, k;
    rst_len = 8;
    mid(); mid();
    tests++; if (phase_out !== 2'd0) begin fails++; $display("FAIL reset_phase: got %0d want 0", phase_out); end
    tests++; if ({rst_start_out, step_start_out, draw_start_out} !== 3'b000) begin fails++; $display("FAIL reset_starts: got %b want 000", {rst_start_out, step_start_out, draw_start_out}); end
    tests++; if (mem_we_out !== 1'b0 || mem_addr_out !== '0 || mem_data_out !== '0) begin fails++; $display("FAIL reset_mem: we=%b addr=%h data=%h want 0", mem_we_out, mem_addr_out, mem_data_out); end
    tests++; if (frame_count_out !== 16'd0 || overrun_out !== 1'b0) begin fails++; $display("FAIL reset_status: frame=%0d ovr=%b want 0/0", frame_count_out, overrun_out); end
    rst_in = 1'b0;
    we0 = n_we; go0 = n_rst_go;
    mid();
    tests++; if (phase_out !== 2'd1 || rst_start_out !== 1'b1) begin fails++; $display("FAIL auto_reset_launch: phase=%0d start=%b want 1/1", phase_out, rst_start_out); end
    mid();
    tests++; if (mem_we_out !== 1'b1 || mem_addr_out !== RST_ADDR || mem_data_out !== RST_DATA) begin fails++; $display("FAIL reset_mux: we=%b addr=%h data=%h", mem_we_out, mem_addr_out, mem_data_out); end
    for (k = 0; k < 40; k++) begin
      if (phase_out == 2'd0) break;
      mid();
    end
    tests++; if (phase_out !== 2'd0) begin fails++; $display("FAIL reset_return_idle: phase=%0d want 0 (timeout)", phase_out); end
    tests++; if (n_we - we0 !== 8) begin fails++; $display("FAIL reset_we_cycles: got %0d want 8", n_we - we0); end
    tests++; if (n_rst_go - go0 !== 1) begin fails++; $display("FAIL reset_start_pulses: got %0d want 1", n_rst_go - go0); end
    tests++; if (frame_count_out !== 16'd0) begin fails++; $display("FAIL reset_frame: got %0d want 0", frame_count_out); end
    tests++; if (mem_we_out !== 1'b0 || mem_addr_out !== '0) begin fails++; $display("FAIL idle_mux: we=%b addr=%h want 0/0", mem_we_out, mem_addr_out); end
  endtask

  task automatic test_frame();
    int dw0, sg0, t_draw, t_idle;
    step_len = 5; draw_len = 3; step_we_in = 1'b1;
    t_draw = -1; t_idle = -1;
    frame_tick_in = 1'b1;
    mid();
    frame_tick_in = 1'b0;
    tests++; if (phase_out !== 2'd2 || step_start_out !== 1'b1) begin fails++; $display("FAIL step_launch: phase=%0d start=%b want 2/1", phase_out, step_start_out); end
    tests++; if (mem_we_out !== 1'b1 || mem_addr_out !== STEP_ADDR || mem_data_out !== STEP_DATA) begin fails++; $display("FAIL step_mux: we=%b addr=%h data=%h", mem_we_out, mem_addr_out, mem_data_out); end
    dw0 = n_draw_we; sg0 = n_step_go;
    for (int k = 2; k <= 40; k++) begin
      mid();
      if (draw_start_out && t_draw < 0) begin
        t_draw = k;
        tests++; if (phase_out !== 2'd3 || mem_addr_out !== DRAW_ADDR || mem_data_out !== '0) begin fails++; $display("FAIL draw_mux: phase=%0d addr=%h data=%h", phase_out, mem_addr_out, mem_data_out); end
      end
      if (phase_out == 2'd0) begin t_idle = k; break; end
    end
    tests++; if (t_draw !== 8) begin fails++; $display("FAIL draw_handoff: draw start at cycle %0d want 8", t_draw); end
    tests++; if (t_idle !== 13) begin fails++; $display("FAIL frame_done: idle at cycle %0d want 13", t_idle); end
    tests++; if (frame_count_out !== 16'd1) begin fails++; $display("FAIL frame_count: got %0d want 1", frame_count_out); end
    tests++; if (n_draw_we - dw0 !== 0) begin fails++; $display("FAIL draw_we: got %0d cycles want 0", n_draw_we - dw0); end
    tests++; if (n_step_go - sg0 !== 0) begin fails++; $display("FAIL extra_step: got %0d want 0", n_step_go - sg0); end
    tests++; if (mem_we_out !== 1'b0) begin fails++; $display("FAIL idle_ignores_step_we: got %b want 0", mem_we_out); end
  endtask

  task automatic test_restart_in_draw();
    step_len = 2; draw_len = 4; rst_len = 3;
    frame_tick_in = 1'b1;
    mid();
    frame_tick_in = 1'b0;
    for (int k = 2; k <= 18; k++) begin
      mid();
      restart_in = (k == 6);
      if (k == 5) begin tests++; if (draw_start_out !== 1'b1) begin fails++; $display("FAIL rd_draw_start: got %b want 1", draw_start_out); end end
      if (k == 10) begin tests++; if (phase_out !== 2'd3) begin fails++; $display("FAIL rd_no_abort: phase=%0d want 3", phase_out); end end
      if (k == 11) begin tests++; if (phase_out !== 2'd0 || frame_count_out !== 16'd2) begin fails++; $display("FAIL rd_draw_done: phase=%0d frame=%0d want 0/2", phase_out, frame_count_out); end end
      if (k == 12) begin tests++; if (phase_out !== 2'd1 || rst_start_out !== 1'b1) begin fails++; $display("FAIL rd_reset_launch: phase=%0d start=%b want 1/1", phase_out, rst_start_out); end end
      if (k == 17) begin tests++; if (phase_out !== 2'd0 || frame_count_out !== 16'd0) begin fails++; $display("FAIL rd_frame_clear: phase=%0d frame=%0d want 0/0", phase_out, frame_count_out); end end
      if (k == 18) begin tests++; if (phase_out !== 2'd0) begin fails++; $display("FAIL rd_pending_cleared: phase=%0d want 0", phase_out); end end
    end
  endtask

  task automatic test_overrun();
    int sg0;
    step_len = 6; draw_len = 1; rst_len = 2;
    frame_tick_in = 1'b1;
    mid();
    frame_tick_in = 1'b0;
    sg0 = n_step_go;
    for (int k = 2; k <= 19; k++) begin
      mid();
      frame_tick_in = (k == 3);
      restart_in = (k == 14);
      if (k == 2) begin tests++; if (overrun_out !== 1'b0) begin fails++; $display("FAIL ovr_initial: got %b want 0", overrun_out); end end
      if (k == 4) begin tests++; if (overrun_out !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b want 1", overrun_out); end end
      if (k == 12) begin tests++; if (phase_out !== 2'd0 || overrun_out !== 1'b1 || frame_count_out !== 16'd1) begin fails++; $display("FAIL ovr_frame_end: phase=%0d ovr=%b frame=%0d want 0/1/1", phase_out, overrun_out, frame_count_out); end end
      if (k == 14) begin tests++; if (overrun_out !== 1'b1 || n_step_go - sg0 !== 0) begin fails++; $display("FAIL ovr_sticky: ovr=%b extra_steps=%0d want 1/0", overrun_out, n_step_go - sg0); end end
      if (k == 15) begin tests++; if (phase_out !== 2'd1) begin fails++; $display("FAIL ovr_restart: phase=%0d want 1", phase_out); end end
      if (k == 19) begin tests++; if (phase_out !== 2'd0 || overrun_out !== 1'b0 || frame_count_out !== 16'd0) begin fails++; $display("FAIL ovr_cleared: phase=%0d ovr=%b frame=%0d want 0/0/0", phase_out, overrun_out, frame_count_out); end end
    end
  endtask

  task automatic test_coincident();
    int rg0, sg0;
    rst_len = 4;
    restart_in = 1'b1; frame_tick_in = 1'b1;
    mid();
    restart_in = 1'b0; frame_tick_in = 1'b0;
    tests++; if (phase_out !== 2'd1 || rst_start_out !== 1'b1 || overrun_out !== 1'b0) begin fails++; $display("FAIL coinc_restart_wins: phase=%0d start=%b ovr=%b want 1/1/0", phase_out, rst_start_out, overrun_out); end
    rg0 = n_rst_go; sg0 = n_step_go;
    for (int k = 2; k <= 9; k++) begin
      mid();
      restart_in = (k == 3);
      if (k == 7) begin tests++; if (phase_out !== 2'd0) begin fails++; $display("FAIL coinc_reset_done: phase=%0d want 0", phase_out); end end
    end
    tests++; if (phase_out !== 2'd0 || n_rst_go - rg0 !== 0 || n_step_go - sg0 !== 0) begin fails++; $display("FAIL coinc_restart_ignored: phase=%0d rst_go=%0d step_go=%0d want 0/0/0", phase_out, n_rst_go - rg0, n_step_go - sg0); end
  endtask

  task automatic test_timeout();
    step_len = 0; draw_len = 0;
    frame_tick_in = 1'b1;
    mid();
    frame_tick_in = 1'b0;
    for (int k = 2; k <= 11; k++) begin
      mid();
      if (k == 5) begin tests++; if (phase_out !== 2'd2) begin fails++; $display("FAIL tmo_step_wait: phase=%0d want 2", phase_out); end end
      if (k == 6) begin tests++; if (phase_out !== 2'd3 || draw_start_out !== 1'b1) begin fails++; $display("FAIL tmo_step_done: phase=%0d draw_start=%b want 3/1", phase_out, draw_start_out); end end
      if (k == 10) begin tests++; if (phase_out !== 2'd3) begin fails++; $display("FAIL tmo_draw_wait: phase=%0d want 3", phase_out); end end
    end
    tests++; if (phase_out !== 2'd0 || frame_count_out !== 16'd1) begin fails++; $display("FAIL tmo_idle: phase=%0d frame=%0d want 0/1", phase_out, frame_count_out); end
  endtask

  task automatic test_rst_midstep();
    int k;
    step_len = 10; rst_len = 2; step_we_in = 1'b1;
    frame_tick_in = 1'b1;
    mid();
    frame_tick_in = 1'b0;
    mid();
    frame_tick_in = 1'b1;
    mid();
    frame_tick_in = 1'b0;
    tests++; if (mem_we_out !== 1'b1 || overrun_out !== 1'b1 || frame_count_out !== 16'd1) begin fails++; $display("FAIL mid_pre: we=%b ovr=%b frame=%0d want 1/1/1", mem_we_out, overrun_out, frame_count_out); end
    rst_in = 1'b1;
    #1;
    tests++; if (mem_we_out !== 1'b0 || mem_addr_out !== '0 || mem_data_out !== '0) begin fails++; $display("FAIL mid_async_mem: we=%b addr=%h data=%h want 0", mem_we_out, mem_addr_out, mem_data_out); end
    tests++; if (phase_out !== 2'd0 || overrun_out !== 1'b0 || frame_count_out !== 16'd0 || step_start_out !== 1'b0) begin fails++; $display("FAIL mid_async_state: phase=%0d ovr=%b frame=%0d start=%b want 0", phase_out, overrun_out, frame_count_out, step_start_out); end
    mid();
    rst_in = 1'b0;
    mid();
    tests++; if (phase_out !== 2'd1 || rst_start_out !== 1'b1) begin fails++; $display("FAIL mid_auto_reset: phase=%0d start=%b want 1/1", phase_out, rst_start_out); end
    for (k = 0; k < 40; k++) begin
      if (phase_out == 2'd0) break;
      mid();
    end
    tests++; if (phase_out !== 2'd0 || frame_count_out !== 16'd0) begin fails++; $display("FAIL mid_reset_done: phase=%0d frame=%0d want 0/0 (timeout)", phase_out, frame_count_out); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_restart_in_draw();
    test_overrun();
    test_coincident();
    test_timeout();
    test_rst_midstep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
